// File: rtl/seg7_pkg.sv
// Shared 7-segment encoding: hex nibble to active-high {g,f,e,d,c,b,a} pattern.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
//
// Contents:
//   NIB_W      width of one display nibble
//   SEG7_HEX   16-entry segment table, entry n = pattern for hex digit n
//   hex_to_seg table lookup helper
package seg7_pkg;

   localparam int NIB_W = 4;

   // Packed so entry 0 sits in the low bits; listed F down to 0.
   localparam logic [15:0][6:0] SEG7_HEX = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [6:0] hex_to_seg(input logic [NIB_W-1:0] i_nib);
      return SEG7_HEX[i_nib];
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
//
// Ports:
//   i_nib  in  4  hex digit 0-F
//   o_seg  out 7  segments {g,f,e,d,c,b,a}, bit0 = a, active-high
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [NIB_W-1:0] i_nib,
   output logic [6:0]       o_seg
);

   assign o_seg = hex_to_seg(i_nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-digit 7-segment scan driver with frame-aligned update.
// Latency: seg/dp/an/frame_done are registered, one cycle behind the slot counters.
// Backpressure: none; load is always accepted into pending, shown from the next frame.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   data_in      nibble i = data_in[4i+3:4i], digit 0 least significant
//   dp_in        decimal point request per digit
//   load         capture data_in/dp_in into pending this cycle (last load wins)
//   blank_lz     enable leading-zero blanking (digit 0 never blanked)
//   seg, dp      segment pattern and decimal point, polarity set by SEG_ACT_LOW
//   an           one-hot digit enable (all inactive during guard), polarity by AN_ACT_LOW
//   frame_done   one-cycle pulse aligned with the final output cycle of the last slot
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int SLOT_CYC    = 50000,
   parameter int GUARD       = 16,
   parameter bit SEG_ACT_LOW = 1'b0,
   parameter bit AN_ACT_LOW  = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NIB_W*DIGITS-1:0] data_in,
   input  logic [DIGITS-1:0]       dp_in,
   input  logic                    load,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [DIGITS-1:0]       an,
   output logic                    frame_done
);

   localparam int SCW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
   localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [SCW-1:0]    SLOT_LAST = SCW'(SLOT_CYC - 1);
   localparam logic [SCW-1:0]    GUARD_END = SCW'(GUARD);
   localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
   localparam logic [6:0]        SEG_OFF   = {7{SEG_ACT_LOW}};
   localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{AN_ACT_LOW}};

   logic [SCW-1:0]          r_slot_cnt;
   logic [IW-1:0]           r_idx;
   logic [NIB_W*DIGITS-1:0] r_pend_dat;
   logic [DIGITS-1:0]       r_pend_dp;
   logic [NIB_W*DIGITS-1:0] r_act_dat;
   logic [DIGITS-1:0]       r_act_dp;
   logic [6:0]              r_seg;
   logic                    r_dp;
   logic [DIGITS-1:0]       r_an;
   logic                    r_frame_done;

   logic                    w_slot_wrap;
   logic                    w_frame_end;
   logic                    w_guard;
   logic [NIB_W-1:0]        w_nib;
   logic                    w_dp_bit;
   logic                    w_upper_zero;
   logic                    w_blank;
   logic [6:0]              w_seg_dec;
   logic [6:0]              w_seg_hi;
   logic [DIGITS-1:0]       w_an_hi;

   assign w_slot_wrap = (r_slot_cnt == SLOT_LAST);
   assign w_frame_end = w_slot_wrap && (r_idx == IDX_LAST);
   assign w_guard     = (r_slot_cnt < GUARD_END);

   // Slot prescaler and digit index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot_cnt <= '0;
         r_idx      <= '0;
      end else if (w_slot_wrap) begin
         r_slot_cnt <= '0;
         r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
      end else begin
         r_slot_cnt <= r_slot_cnt + SCW'(1);
      end
   end

   // Pending captures every load; active only moves at the frame boundary.
   // Non-blocking update means a load in the boundary cycle stays in pending
   // while active takes the older pending value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_dat <= '0;
         r_pend_dp  <= '0;
         r_act_dat  <= '0;
         r_act_dp   <= '0;
      end else begin
         if (load) begin
            r_pend_dat <= data_in;
            r_pend_dp  <= dp_in;
         end
         if (w_frame_end) begin
            r_act_dat <= r_pend_dat;
            r_act_dp  <= r_pend_dp;
         end
      end
   end

   // Digit mux plus "this digit and everything above it is zero" detect.
   // Loop-compare form stays in range when DIGITS is not a power of two.
   always_comb begin
      w_nib        = '0;
      w_dp_bit     = 1'b0;
      w_upper_zero = 1'b1;
      for (int j = 0; j < DIGITS; j++) begin
         if (IW'(j) == r_idx) begin
            w_nib    = r_act_dat[NIB_W*j +: NIB_W];
            w_dp_bit = r_act_dp[j];
         end
         if ((IW'(j) >= r_idx) && (r_act_dat[NIB_W*j +: NIB_W] != '0)) begin
            w_upper_zero = 1'b0;
         end
      end
   end

   assign w_blank = blank_lz && w_upper_zero && (r_idx != '0);

   hex_to_seg7 u_dec (
      .i_nib (w_nib),
      .o_seg (w_seg_dec)
   );

   assign w_seg_hi = w_blank ? 7'h00 : w_seg_dec;

   always_comb begin
      w_an_hi = '0;
      for (int j = 0; j < DIGITS; j++) begin
         w_an_hi[j] = (IW'(j) == r_idx) && !w_guard;
      end
   end

   // Output registers: an and seg update on the same edge so a new digit
   // never appears with the previous digit's segments.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg        <= SEG_OFF;
         r_dp         <= SEG_ACT_LOW;
         r_an         <= AN_OFF;
         r_frame_done <= 1'b0;
      end else begin
         r_seg        <= w_seg_hi ^ SEG_OFF;
         r_dp         <= w_dp_bit ^ SEG_ACT_LOW;
         r_an         <= w_an_hi ^ AN_OFF;
         r_frame_done <= w_frame_end;
      end
   end

   assign seg        = r_seg;
   assign dp         = r_dp;
   assign an         = r_an;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: DIGITS=4, SLOT_CYC=8, GUARD=2.
// Two instances share stimulus: active-high outputs and fully active-low outputs.
// Expected outputs come from an absolute-cycle-count model plus literal pins.
module tb_seg7_scan_driver;

   localparam int DIG   = 4;
   localparam int SLOT  = 8;
   localparam int GRD   = 2;
   localparam int FRAME = DIG * SLOT;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic [15:0] data_in  = '0;
   logic [3:0]  dp_in    = '0;
   logic        load     = 1'b0;
   logic        blank_lz = 1'b0;

   logic [6:0] seg, seg_lo;
   logic       dp, dp_lo;
   logic [3:0] an, an_lo;
   logic       fd, fd_lo;

   always #5 clk = ~clk;

   seg7_scan_driver #(.DIGITS(DIG), .SLOT_CYC(SLOT), .GUARD(GRD),
                      .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_done(fd));

   seg7_scan_driver #(.DIGITS(DIG), .SLOT_CYC(SLOT), .GUARD(GRD),
                      .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)) u_dut_lo (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .load(load),
      .blank_lz(blank_lz), .seg(seg_lo), .dp(dp_lo), .an(an_lo), .frame_done(fd_lo));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   function automatic int f_idx(input int unsigned c);
      return int'((c / SLOT) % DIG);
   endfunction

   function automatic logic [3:0] f_an(input int unsigned c);
      if ((c % SLOT) < GRD) return 4'b0000;
      return 4'(1 << f_idx(c));
   endfunction

   function automatic logic [6:0] f_seg(input int unsigned c, input logic [15:0] act, input logic bl);
      int          idx   = f_idx(c);
      logic [15:0] upper = act >> (4 * idx);
      if (bl && idx != 0 && upper == 16'h0) return 7'h00;
      return hex_tab[act[4*idx +: 4]];
   endfunction

   function automatic logic f_fd(input int unsigned c);
      return (c % FRAME) == FRAME - 1;
   endfunction

   int unsigned m_cyc     = 0;
   logic [15:0] m_pend    = '0;
   logic [15:0] m_act     = '0;
   logic [3:0]  m_pend_dp = '0;
   logic [3:0]  m_act_dp  = '0;
   logic [6:0]  e_seg     = '0;
   logic        e_dp      = 1'b0;
   logic [3:0]  e_an      = '0;
   logic        e_fd      = 1'b0;

   // m_cyc is the number of clock edges since reset release; the outputs seen
   // in a cycle are those implied by the previous cycle's count.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc     <= 0;
         m_pend    <= '0;
         m_act     <= '0;
         m_pend_dp <= '0;
         m_act_dp  <= '0;
         e_seg     <= '0;
         e_dp      <= 1'b0;
         e_an      <= '0;
         e_fd      <= 1'b0;
      end else begin
         e_an  <= f_an(m_cyc);
         e_seg <= f_seg(m_cyc, m_act, blank_lz);
         e_dp  <= m_act_dp[f_idx(m_cyc)];
         e_fd  <= f_fd(m_cyc);
         if (f_fd(m_cyc)) begin
            m_act    <= m_pend;
            m_act_dp <= m_pend_dp;
         end
         if (load) begin
            m_pend    <= data_in;
            m_pend_dp <= dp_in;
         end
         m_cyc <= m_cyc + 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("an", {28'b0, an}, {28'b0, e_an});
      chk("an_lo", {28'b0, an_lo}, {28'b0, 4'(~e_an)});
      chk("frame_done", {31'b0, fd}, {31'b0, e_fd});
      chk("frame_done_lo", {31'b0, fd_lo}, {31'b0, e_fd});
      if (e_an != 4'b0000) begin
         chk("seg", {25'b0, seg}, {25'b0, e_seg});
         chk("dp", {31'b0, dp}, {31'b0, e_dp});
         chk("seg_lo", {25'b0, seg_lo}, {25'b0, 7'(~e_seg)});
         chk("dp_lo", {31'b0, dp_lo}, {31'b0, 1'(~e_dp)});
      end
   end

   // ---------------- directed helpers ----------------
   logic [6:0] cap_seg    [4];
   logic [6:0] cap_seg_lo [4];
   logic       cap_dp     [4];
   logic [3:0] cap_an     [4];
   logic [3:0] cap_an_lo  [4];

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fd(output int n);
      logic seen;
      seen = 1'b0;
      n    = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         n++;
         if (fd) seen = 1'b1;
      end
      chk("frame_done_seen", {31'b0, seen}, 32'd1);
   endtask

   // Call right after wait_fd: samples mid-slot (past the guard) of each digit.
   task automatic capture();
      for (int k = 0; k < 4; k++) begin
         repeat ((k == 0) ? 5 : 8) @(negedge clk);
         cap_seg[k]    = seg;
         cap_seg_lo[k] = seg_lo;
         cap_dp[k]     = dp;
         cap_an[k]     = an;
         cap_an_lo[k]  = an_lo;
      end
   endtask

   task automatic check_frame(input string name, input logic [27:0] exp_segs);
      for (int k = 0; k < 4; k++) begin
         chk({name, "_seg"}, {25'b0, cap_seg[k]}, {25'b0, exp_segs[7*k +: 7]});
         chk({name, "_an"}, {28'b0, cap_an[k]}, {28'b0, 4'(1 << k)});
      end
   endtask

   task automatic post_reset_checks();
      @(negedge clk);
      chk("rst_seg", {25'b0, seg}, 32'h00);
      chk("rst_dp", {31'b0, dp}, 32'h0);
      chk("rst_seg_lo", {25'b0, seg_lo}, 32'h7F);
      chk("rst_an_lo", {28'b0, an_lo}, 32'hF);
      chk("rst_an_c0", {28'b0, an}, 32'h0);
      @(negedge clk);
      chk("rst_an_c1", {28'b0, an}, 32'h0);
      @(negedge clk);
      chk("rst_an_c2", {28'b0, an}, 32'h0);
      @(negedge clk);
      chk("first_an_c3", {28'b0, an}, 32'h1);
      chk("first_seg_c3", {25'b0, seg}, 32'h3F);
   endtask

   // ---------------- stimulus ----------------
   int  n;
   logic hit;

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      post_reset_checks();

      // Mid-frame load must not disturb the frame being shown.
      sync();
      data_in = 16'h12AF; load = 1'b1;
      sync();
      load = 1'b0;
      @(negedge clk);
      chk("hold_old_seg", {25'b0, seg}, 32'h3F);
      wait_fd(n);
      chk("first_fd_cycle", n, 32'd27);
      capture();
      check_frame("load12AF", {7'h06, 7'h5B, 7'h77, 7'h71});
      wait_fd(n);
      chk("fd_gap_short", n, 32'd3);
      wait_fd(n);
      chk("fd_period", n, 32'd32);

      // Leading-zero blanking on, then off.
      sync();
      data_in = 16'h0005; load = 1'b1; blank_lz = 1'b1;
      sync();
      load = 1'b0;
      wait_fd(n);
      capture();
      check_frame("lz_on", {7'h00, 7'h00, 7'h00, 7'h6D});
      sync();
      blank_lz = 1'b0;
      wait_fd(n);
      capture();
      check_frame("lz_off", {7'h3F, 7'h3F, 7'h3F, 7'h6D});

      // All zero with a decimal point on a blanked digit.
      sync();
      data_in = 16'h0000; dp_in = 4'b0100; load = 1'b1; blank_lz = 1'b1;
      sync();
      load = 1'b0;
      wait_fd(n);
      capture();
      check_frame("zero_dp", {7'h00, 7'h00, 7'h00, 7'h3F});
      chk("zero_dp_d2", {31'b0, cap_dp[2]}, 32'd1);
      chk("zero_dp_d0", {31'b0, cap_dp[0]}, 32'd0);

      // Active-low instance on all-8s.
      sync();
      data_in = 16'h8888; dp_in = 4'b0000; load = 1'b1;
      sync();
      load = 1'b0;
      wait_fd(n);
      capture();
      check_frame("eights", {7'h7F, 7'h7F, 7'h7F, 7'h7F});
      for (int k = 0; k < 4; k++) begin
         chk("lo_seg8", {25'b0, cap_seg_lo[k]}, 32'h00);
         chk("lo_an", {28'b0, cap_an_lo[k]}, {28'b0, 4'(~(4'b0001 << k))});
      end

      // Reset in digit 2's slot with a load still pending.
      sync();
      blank_lz = 1'b0;
      wait_fd(n);
      sync();
      data_in = 16'h4321; load = 1'b1;
      sync();
      load = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         if (an == 4'b0100) hit = 1'b1;
      end
      chk("idx2_reached", {31'b0, hit}, 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_an", {28'b0, an}, 32'h0);
      chk("arst_seg", {25'b0, seg}, 32'h00);
      chk("arst_fd", {31'b0, fd}, 32'h0);
      chk("arst_an_lo", {28'b0, an_lo}, 32'hF);
      chk("arst_seg_lo", {25'b0, seg_lo}, 32'h7F);
      sync();
      sync();
      rst_n = 1'b1;
      post_reset_checks();
      wait_fd(n);
      chk("rst_fd_cycle", n, 32'd29);
      capture();
      check_frame("pend_cleared", {7'h3F, 7'h3F, 7'h3F, 7'h3F});

      // Randomised traffic, checked every cycle by the model.
      for (int c = 0; c < 3000; c++) begin
         sync();
         load = ($urandom_range(9) == 0);
         for (int d = 0; d < 4; d++)
            data_in[4*d +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
         dp_in = 4'($urandom_range(15));
         if ($urandom_range(49) == 0) blank_lz = ~blank_lz;
      end
      sync();
      load = 1'b0;
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
